factorial_ctrl_p: RTL

Parametrised successor to the single-mode factorial controller. Sequences an external WIDTH-bit multiplier through start/clear/done handshakes to compute either n! or the falling factorial n!/(n-k)!. Adds a sticky overflow flag, a maskable completion interrupt, and correct handling of the degenerate operands. Sits between the bus-facing register file (opstart/opclear/operand) and the shared multiplier core.

---
 rtl/factorial_pkg.sv | 20 ++
 rtl/factorial_ctrl_p_if.sv | 36 +++
 rtl/factorial_ctrl_dp.sv | 76 +++++++
 rtl/factorial_ctrl_p.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/factorial_pkg.sv
// Shared encodings for the factorial controller: FSM states, opdone status codes and mode values.
package factorial_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MUL  = 3'd2,
      CLR  = 3'd3,
      NEXT = 3'd4,
      DONE = 3'd5
   } state_e;

   localparam logic [1:0] OPD_IDLE = 2'd0;
   localparam logic [1:0] OPD_BUSY = 2'd2;
   localparam logic [1:0] OPD_DONE = 2'd3;

   localparam logic MODE_FACT = 1'b0;
   localparam logic MODE_FALL = 1'b1;

endpackage

// File: rtl/factorial_ctrl_p_if.sv
// Register-file and multiplier-core signals of the factorial controller.
interface factorial_ctrl_p_if #(
   parameter int unsigned WIDTH = 64
);
   logic             opstart;
   logic             opclear;
   logic             mode;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] count;
   logic             intr_en;
   logic             mul_op_done;
   logic [WIDTH-1:0] mul_result_h;
   logic [WIDTH-1:0] mul_result_l;
   logic             mul_op_start;
   logic             mul_op_clear;
   logic [WIDTH-1:0] multiplier;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] result;
   logic [1:0]       opdone;
   logic             overflow;
   logic             intr;

   modport master (
      output opstart, opclear, mode, operand, count, intr_en,
      output mul_op_done, mul_result_h, mul_result_l,
      input  mul_op_start, mul_op_clear, multiplier, multiplicand,
      input  result, opdone, overflow, intr
   );

   modport slave (
      input  opstart, opclear, mode, operand, count, intr_en,
      input  mul_op_done, mul_result_h, mul_result_l,
      output mul_op_start, mul_op_clear, multiplier, multiplicand,
      output result, opdone, overflow, intr
   );
endinterface

// File: rtl/factorial_ctrl_dp.sv
// Factorial datapath: running product, next factor, remaining-multiply count, result and
// sticky overflow, driven by load/capture/decrement strobes from the controller FSM.
module factorial_ctrl_dp
   import factorial_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clear,
   input  logic             i_clr_ovf,
   input  logic             i_load,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_operand,
   input  logic [WIDTH-1:0] i_count,
   input  logic             i_set_res,
   input  logic [WIDTH-1:0] i_res_val,
   input  logic             i_capture,
   input  logic [WIDTH-1:0] i_prod_h,
   input  logic [WIDTH-1:0] i_prod_l,
   input  logic             i_dec,
   output logic [WIDTH-1:0] o_multiplier,
   output logic [WIDTH-1:0] o_multiplicand,
   output logic [WIDTH-1:0] o_result,
   output logic             o_overflow,
   output logic             o_last
);

   localparam logic [WIDTH-1:0] One = WIDTH'(1);
   localparam logic [WIDTH-1:0] Two = WIDTH'(2);

   logic [WIDTH-1:0] r_multiplier;
   logic [WIDTH-1:0] r_multiplicand;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_result;
   logic             r_overflow;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_multiplier   <= '0;
         r_multiplicand <= '0;
         r_rem          <= '0;
         r_result       <= '0;
         r_overflow     <= 1'b0;
      end else if (i_clear) begin
         r_result   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (i_clr_ovf) r_overflow <= 1'b0;
         if (i_load) begin
            r_multiplier   <= i_operand;
            r_multiplicand <= i_operand - One;
            // rem = multiplies still to issue, including the first one
            r_rem          <= (i_mode == MODE_FACT) ? i_operand - Two : i_count - One;
            r_result       <= '0;
         end
         if (i_capture) begin
            r_multiplier <= i_prod_l;
            r_overflow   <= r_overflow | (|i_prod_h);
         end
         if (i_set_res) r_result <= i_res_val;
         if (i_dec) begin
            r_multiplicand <= r_multiplicand - One;
            r_rem          <= r_rem - One;
         end
      end
   end

   assign o_multiplier   = r_multiplier;
   assign o_multiplicand = r_multiplicand;
   assign o_result       = r_result;
   assign o_overflow     = r_overflow;
   // rem of 0 only arises for 2!, which needs just the single 2*1 multiply
   assign o_last         = (r_rem <= One);

endmodule

// File: rtl/factorial_ctrl_p.sv
// Factorial / falling-factorial sequencer driving an external multiplier through
// start/clear/done handshakes; FSM here, arithmetic registers in factorial_ctrl_dp.
module factorial_ctrl_p
   import factorial_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input logic               clk,
   input logic               reset_n,
   factorial_ctrl_p_if.slave bus
);

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   state_e     r_state;
   logic       r_start;
   logic       r_clear;
   logic [1:0] r_opdone;
   logic       r_intr;

   logic             w_deg;
   logic [WIDTH-1:0] w_deg_res;
   logic             w_go;
   logic             w_capture;
   logic             w_last;
   logic             w_set_res;
   logic [WIDTH-1:0] w_res_val;

   // Degenerate operands finish straight from IDLE without touching the multiplier
   always_comb begin
      w_deg     = 1'b1;
      w_deg_res = '0;
      if (bus.mode == MODE_FALL) begin
         if (bus.count == '0)              w_deg_res = One;
         else if (bus.count == One)        w_deg_res = bus.operand;
         else if (bus.count > bus.operand) w_deg_res = '0;
         else                              w_deg     = 1'b0;
      end else begin
         if (bus.operand <= One) w_deg_res = One;
         else                    w_deg     = 1'b0;
      end
   end

   assign w_go      = (r_state == IDLE) && bus.opstart && !bus.opclear;
   assign w_capture = (r_state == MUL) && bus.mul_op_done && !bus.opclear;
   assign w_set_res = (w_go && w_deg) || (w_capture && w_last);
   assign w_res_val = (r_state == IDLE) ? w_deg_res : bus.mul_result_l;

   factorial_ctrl_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_clear        (bus.opclear),
      .i_clr_ovf      (w_go),
      .i_load         (w_go && !w_deg),
      .i_mode         (bus.mode),
      .i_operand      (bus.operand),
      .i_count        (bus.count),
      .i_set_res      (w_set_res),
      .i_res_val      (w_res_val),
      .i_capture      (w_capture),
      .i_prod_h       (bus.mul_result_h),
      .i_prod_l       (bus.mul_result_l),
      .i_dec          ((r_state == NEXT) && !bus.opclear),
      .o_multiplier   (bus.multiplier),
      .o_multiplicand (bus.multiplicand),
      .o_result       (bus.result),
      .o_overflow     (bus.overflow),
      .o_last         (w_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_start  <= 1'b0;
         r_clear  <= 1'b0;
         r_opdone <= OPD_IDLE;
         r_intr   <= 1'b0;
      end else if (bus.opclear) begin
         r_state  <= IDLE;
         r_start  <= 1'b0;
         r_clear  <= 1'b1;
         r_opdone <= OPD_IDLE;
         r_intr   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_start  <= 1'b0;
               r_clear  <= 1'b1;
               r_opdone <= OPD_IDLE;
               r_intr   <= 1'b0;
               if (bus.opstart) begin
                  r_clear <= 1'b0;
                  if (w_deg) begin
                     r_state  <= DONE;
                     r_opdone <= OPD_DONE;
                     r_intr   <= bus.intr_en;
                  end else begin
                     r_state  <= LOAD;
                     r_opdone <= OPD_BUSY;
                  end
               end
            end
            LOAD: begin
               r_state <= MUL;
               r_start <= 1'b1;
            end
            MUL: begin
               if (bus.mul_op_done) begin
                  r_start <= 1'b0;
                  if (w_last) begin
                     r_state  <= DONE;
                     r_opdone <= OPD_DONE;
                     r_intr   <= bus.intr_en;
                  end else begin
                     r_state <= CLR;
                     r_clear <= 1'b1;
                  end
               end
            end
            CLR: begin
               r_state <= NEXT;
               r_clear <= 1'b0;
            end
            NEXT: begin
               r_state <= MUL;
               r_start <= 1'b1;
            end
            DONE: begin
               r_opdone <= OPD_DONE;
               r_intr   <= bus.intr_en;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mul_op_start = r_start;
   assign bus.mul_op_clear = r_clear;
   assign bus.opdone       = r_opdone;
   assign bus.intr         = r_intr;

endmodule
